// File: rtl/dht11_sched_pkg.sv
// Shared types for the DHT11 measurement scheduler.
//   state_e : scheduler state encoding (also driven onto o_state for LEDs)
//   fail_e  : cause of the most recent failed measurement try
//   max3, width_of : constant helpers for sizing counters
package dht11_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        START   = 3'd2,
        MEASURE = 3'd3
    } state_e;

    typedef enum logic [1:0] {
        FAIL_NONE = 2'd0,
        FAIL_CSUM = 2'd1,
        FAIL_TMO  = 2'd2
    } fail_e;

    // Largest of three values, used to size the shared millisecond counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int width_of(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/dht11_scheduler_if.sv
// Scheduler-side signal bundle.
//   master : the scheduler (samples i_* from mode logic and controller, drives o_*)
//   slave  : the surrounding logic (drives i_*, consumes o_*)
// RETRY_W must equal width_of(MAX_RETRY) of the scheduler it is bound to.
interface dht11_scheduler_if #(
    parameter int RETRY_W = 2
);
    logic               i_tick;
    logic               i_enable;
    logic               i_trig;
    logic               o_start;
    logic               i_done;
    logic               i_valid;
    logic [15:0]        i_humid;
    logic [15:0]        i_temp;
    logic [15:0]        o_humid;
    logic [15:0]        o_temp;
    logic               o_update;
    logic               o_err;
    logic [1:0]         o_fail_code;
    logic [RETRY_W-1:0] o_retry;
    logic               o_busy;
    logic [2:0]         o_state;

    modport master (
        input  i_tick, i_enable, i_trig, i_done, i_valid, i_humid, i_temp,
        output o_start, o_humid, o_temp, o_update, o_err, o_fail_code,
               o_retry, o_busy, o_state
    );

    modport slave (
        output i_tick, i_enable, i_trig, i_done, i_valid, i_humid, i_temp,
        input  o_start, o_humid, o_temp, o_update, o_err, o_fail_code,
               o_retry, o_busy, o_state
    );
endinterface

// File: rtl/dht11_scheduler_ms_timer.sv
// Millisecond timer: a prescaler counts i_tick pulses and every TICKS_PER_MS
// ticks advances a saturating millisecond counter.
//   clk, rst   : clock, asynchronous active-high reset
//   i_tick     : single-cycle time base pulse
//   i_clr      : synchronous clear of prescaler and ms counter (wins over i_tick)
//   o_ms_cnt   : elapsed milliseconds since the last clear, saturating
module ms_timer #(
    parameter int TICKS_PER_MS = 1000,
    parameter int CNT_W        = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_ms_cnt
);
    localparam int               PSC_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICKS_PER_MS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [PSC_W-1:0] psc_r;
    logic [CNT_W-1:0] ms_cnt_r;

    // Prescaler and saturating ms counter; nothing advances without a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_r    <= {PSC_W{1'b0}};
            ms_cnt_r <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            psc_r    <= {PSC_W{1'b0}};
            ms_cnt_r <= {CNT_W{1'b0}};
        end else if (i_tick) begin
            if (psc_r == PSC_LAST) begin
                psc_r <= {PSC_W{1'b0}};
                if (ms_cnt_r != CNT_MAX) begin
                    ms_cnt_r <= ms_cnt_r + CNT_W'(1'b1);
                end
            end else begin
                psc_r <= psc_r + PSC_W'(1'b1);
            end
        end
    end

    assign o_ms_cnt = ms_cnt_r;

endmodule

// File: rtl/dht11_scheduler.sv
// DHT11 measurement scheduler. Issues start pulses to the sensor controller
// periodically or on manual request, enforces the minimum inter-read gap,
// detects timeouts and checksum failures, retries a bounded number of times
// and keeps the last good humidity/temperature.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dht11_scheduler_if.master (tick, enable, trigger, controller
//              handshake in; start, data, update, error/retry status, busy,
//              state out). All outputs are registered.
module dht11_scheduler
    import dht11_sched_pkg::*;
#(
    parameter int TICKS_PER_MS = 1000,
    parameter int PERIOD_MS    = 2000,
    parameter int MIN_GAP_MS   = 1100,
    parameter int TIMEOUT_MS   = 40,
    parameter int MAX_RETRY    = 3
) (
    input  logic                clk,
    input  logic                rst,
    dht11_scheduler_if.master   bus
);
    localparam int MS_W    = width_of(max3(PERIOD_MS, MIN_GAP_MS, TIMEOUT_MS));
    localparam int RETRY_W = width_of(MAX_RETRY);

    localparam logic [MS_W-1:0]    PERIOD_C  = MS_W'(PERIOD_MS);
    localparam logic [MS_W-1:0]    GAP_C     = MS_W'(MIN_GAP_MS);
    localparam logic [MS_W-1:0]    TMO_C     = MS_W'(TIMEOUT_MS);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    if ((MIN_GAP_MS > PERIOD_MS) || (TIMEOUT_MS >= MIN_GAP_MS)) begin : g_bad_params
        $error("dht11_scheduler: need MIN_GAP_MS <= PERIOD_MS and TIMEOUT_MS < MIN_GAP_MS");
    end

    state_e             state_r;
    logic [MS_W-1:0]    tgt_r;
    logic               pend_r;
    logic [RETRY_W-1:0] retry_r;
    fail_e              fail_code_r;
    logic               err_r;
    logic               start_r;
    logic               update_r;
    logic               busy_r;
    logic [15:0]        humid_r;
    logic [15:0]        temp_r;

    logic [MS_W-1:0]    ms_cnt_s;
    logic               ge_tgt_s;
    logic               ge_gap_s;
    logic               tmo_s;
    logic               hold_go_s;
    logic               leave_s;

    assign ge_tgt_s  = (ms_cnt_s >= tgt_r);
    assign ge_gap_s  = (ms_cnt_s >= GAP_C);
    assign tmo_s     = (ms_cnt_s >= TMO_C);
    // A pending or fresh trigger may only cut the wait short once the gap has elapsed.
    assign hold_go_s = ge_tgt_s || (ge_gap_s && (pend_r || bus.i_trig));

    // Flags the edge on which the FSM changes state, so the timer restarts at
    // zero together with the new state rather than one cycle later.
    always_comb begin
        leave_s = 1'b0;
        case (state_r)
            IDLE:    leave_s = bus.i_enable;
            HOLD:    leave_s = !bus.i_enable || hold_go_s;
            START:   leave_s = 1'b1;
            MEASURE: leave_s = bus.i_done || tmo_s;
            default: leave_s = 1'b1;
        endcase
    end

    ms_timer #(
        .TICKS_PER_MS (TICKS_PER_MS),
        .CNT_W        (MS_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (bus.i_tick),
        .i_clr    (leave_s),
        .o_ms_cnt (ms_cnt_s)
    );

    // Scheduler FSM with all status and data outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            tgt_r       <= {MS_W{1'b0}};
            pend_r      <= 1'b0;
            retry_r     <= {RETRY_W{1'b0}};
            fail_code_r <= FAIL_NONE;
            err_r       <= 1'b0;
            start_r     <= 1'b0;
            update_r    <= 1'b0;
            busy_r      <= 1'b0;
            humid_r     <= 16'h0000;
            temp_r      <= 16'h0000;
        end else begin
            start_r  <= 1'b0;
            update_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    pend_r <= 1'b0;
                    if (bus.i_enable) begin
                        state_r <= HOLD;
                        tgt_r   <= GAP_C;
                    end
                end
                HOLD: begin
                    if (!bus.i_enable) begin
                        state_r <= IDLE;
                        pend_r  <= 1'b0;
                    end else if (hold_go_s) begin
                        state_r <= START;
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                        pend_r  <= 1'b0;
                    end else if (bus.i_trig) begin
                        pend_r  <= 1'b1;
                    end
                end
                START: begin
                    state_r <= MEASURE;
                end
                MEASURE: begin
                    // i_done has priority over a coincident timeout.
                    if (bus.i_done || tmo_s) begin
                        // A dropped enable lets the transaction finish, then parks in IDLE.
                        state_r <= bus.i_enable ? HOLD : IDLE;
                        busy_r  <= 1'b0;
                        if (bus.i_done && bus.i_valid) begin
                            humid_r     <= bus.i_humid;
                            temp_r      <= bus.i_temp;
                            update_r    <= 1'b1;
                            err_r       <= 1'b0;
                            fail_code_r <= FAIL_NONE;
                            retry_r     <= {RETRY_W{1'b0}};
                            tgt_r       <= PERIOD_C;
                        end else begin
                            fail_code_r <= bus.i_done ? FAIL_CSUM : FAIL_TMO;
                            if (retry_r < RETRY_MAX) begin
                                retry_r <= retry_r + RETRY_W'(1'b1);
                                tgt_r   <= GAP_C;
                            end else begin
                                err_r   <= 1'b1;
                                retry_r <= {RETRY_W{1'b0}};
                                tgt_r   <= PERIOD_C;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    pend_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_start     = start_r;
    assign bus.o_update    = update_r;
    assign bus.o_humid     = humid_r;
    assign bus.o_temp      = temp_r;
    assign bus.o_err       = err_r;
    assign bus.o_fail_code = fail_code_r;
    assign bus.o_retry     = retry_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_state     = state_r;

endmodule

// File: tb/tb_dht11_scheduler.sv
// Scoreboard bench for dht11_scheduler. The stimulus thread pushes expected
// output snapshots (cycle, pulses, data, status, state) into a queue; the
// monitor pops one whenever the DUT pulses o_start/o_update or the expected
// cycle is reached, and compares every field.
module tb_dht11_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    // Cycle counter: value is the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    dht11_scheduler_if #(.RETRY_W(2)) bus();

    dht11_scheduler #(
        .TICKS_PER_MS (4),
        .PERIOD_MS    (20),
        .MIN_GAP_MS   (10),
        .TIMEOUT_MS   (5),
        .MAX_RETRY    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic        start;
        logic        upd;
        logic [15:0] humid;
        logic [15:0] temp;
        logic        err;
        logic [1:0]  fc;
        logic [1:0]  retry;
        logic        busy;
        logic [2:0]  state;
    } snap_t;

    snap_t sb_q[$];

    // Model of the data/status the DUT should be holding.
    logic [15:0] m_humid = 16'h0000;
    logic [15:0] m_temp  = 16'h0000;
    logic        m_err   = 1'b0;
    logic [1:0]  m_fc    = 2'd0;
    logic [1:0]  m_retry = 2'd0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_STRT = 3'd2;

    task automatic push(input string name, input int c, input logic st,
                        input logic up, input logic busy, input logic [2:0] state);
        snap_t e;
        e.name  = name;  e.cyc   = c;      e.start = st;    e.upd   = up;
        e.humid = m_humid; e.temp = m_temp; e.err  = m_err; e.fc    = m_fc;
        e.retry = m_retry; e.busy = busy;  e.state = state;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    // Controller model: one i_done pulse sampled on rising edge 'at'.
    task automatic pulse_done(input int at, input logic valid,
                              input logic [15:0] h, input logic [15:0] t);
        wait_to(at - 1);
        bus.i_done  = 1'b1;
        bus.i_valid = valid;
        bus.i_humid = h;
        bus.i_temp  = t;
        step();
        bus.i_done  = 1'b0;
        bus.i_valid = 1'b0;
    endtask

    // Monitor: compare on output pulses or when the expected cycle arrives.
    always @(negedge clk) begin
        snap_t e;
        logic  ev;
        ev = (bus.o_start === 1'b1) || (bus.o_update === 1'b1);
        if (sb_q.size() > 0 && (ev || cyc >= sb_q[0].cyc)) begin
            e = sb_q.pop_front();
            n_vec = n_vec + 1;
            if (cyc != e.cyc || bus.o_start !== e.start || bus.o_update !== e.upd ||
                bus.o_humid !== e.humid || bus.o_temp !== e.temp || bus.o_err !== e.err ||
                bus.o_fail_code !== e.fc || bus.o_retry !== e.retry ||
                bus.o_busy !== e.busy || bus.o_state !== e.state) begin
                n_miss = n_miss + 1;
                $display("FAIL %s: got cyc=%0d st=%b up=%b h=%h t=%h err=%b fc=%0d rty=%0d busy=%b state=%0d; want cyc=%0d st=%b up=%b h=%h t=%h err=%b fc=%0d rty=%0d busy=%b state=%0d",
                         e.name, cyc, bus.o_start, bus.o_update, bus.o_humid, bus.o_temp,
                         bus.o_err, bus.o_fail_code, bus.o_retry, bus.o_busy, bus.o_state,
                         e.cyc, e.start, e.upd, e.humid, e.temp, e.err, e.fc, e.retry,
                         e.busy, e.state);
            end
        end else if (ev) begin
            n_vec = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL unexpected_pulse: got st=%b up=%b at cyc=%0d; want no pulse",
                     bus.o_start, bus.o_update, cyc);
        end
    end

    initial begin
        int    e;
        int    s;
        int    d;
        int    c;
        snap_t left;

        bus.i_tick   = 1'b1;
        bus.i_enable = 1'b0;
        bus.i_trig   = 1'b0;
        bus.i_done   = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_humid  = 16'h0000;
        bus.i_temp   = 16'h0000;

        repeat (3) step();
        rst = 1'b0;
        push("reset_state", cyc + 1, 1'b0, 1'b0, 1'b0, S_IDLE);
        wait_to(cyc + 3);

        // 1: 10 ms settle after enable, success, then a full period.
        bus.i_enable = 1'b1;
        e = cyc + 1;
        s = e + 41;
        push("t1_start_after_settle", s, 1'b1, 1'b0, 1'b1, S_STRT);
        m_humid = 16'h2D00; m_temp = 16'h1A00;
        push("t1_update", s + 3, 1'b0, 1'b1, 1'b0, S_HOLD);
        pulse_done(s + 3, 1'b1, 16'h2D00, 16'h1A00);
        d = s + 3;
        s = d + 81;
        push("t1_start_after_period", s, 1'b1, 1'b0, 1'b1, S_STRT);
        m_humid = 16'h2E00; m_temp = 16'h1B00;
        push("t1_update2", s + 3, 1'b0, 1'b1, 1'b0, S_HOLD);
        pulse_done(s + 3, 1'b1, 16'h2E00, 16'h1B00);

        // 2: early trigger is held pending until the gap; trigger in MEASURE ignored.
        d = s + 3;
        wait_to(d + 12);
        bus.i_trig = 1'b1;
        step();
        bus.i_trig = 1'b0;
        s = d + 41;
        push("t2_start_from_pend", s, 1'b1, 1'b0, 1'b1, S_STRT);
        wait_to(s + 1);
        bus.i_trig = 1'b1;
        step();
        bus.i_trig = 1'b0;
        m_humid = 16'h3000; m_temp = 16'h1C00;
        push("t2_update", s + 5, 1'b0, 1'b1, 1'b0, S_HOLD);
        pulse_done(s + 5, 1'b1, 16'h3000, 16'h1C00);
        d = s + 5;

        // 3: three checksum failures -> retries 1, 2, then error.
        s = d + 81;
        push("t3_start", s, 1'b1, 1'b0, 1'b1, S_STRT);
        m_fc = 2'd1; m_retry = 2'd1;
        push("t3_fail1", s + 3, 1'b0, 1'b0, 1'b0, S_HOLD);
        pulse_done(s + 3, 1'b0, 16'hDEAD, 16'hBEEF);
        s = s + 44;
        push("t3_retry1_start", s, 1'b1, 1'b0, 1'b1, S_STRT);
        m_retry = 2'd2;
        push("t3_fail2", s + 3, 1'b0, 1'b0, 1'b0, S_HOLD);
        pulse_done(s + 3, 1'b0, 16'hDEAD, 16'hBEEF);
        s = s + 44;
        push("t3_retry2_start", s, 1'b1, 1'b0, 1'b1, S_STRT);
        m_retry = 2'd0; m_err = 1'b1;
        push("t3_fail3_err", s + 3, 1'b0, 1'b0, 1'b0, S_HOLD);
        pulse_done(s + 3, 1'b0, 16'hDEAD, 16'hBEEF);

        // 4: timeout at 5 ms, then a successful retry clears the error.
        s = s + 84;
        push("t4_start", s, 1'b1, 1'b0, 1'b1, S_STRT);
        m_fc = 2'd2; m_retry = 2'd1;
        push("t4_timeout", s + 22, 1'b0, 1'b0, 1'b0, S_HOLD);
        s = s + 63;
        push("t4_retry_start", s, 1'b1, 1'b0, 1'b1, S_STRT);
        m_err = 1'b0; m_fc = 2'd0; m_retry = 2'd0;
        m_humid = 16'h2800; m_temp = 16'h1900;
        push("t4_update", s + 3, 1'b0, 1'b1, 1'b0, S_HOLD);
        pulse_done(s + 3, 1'b1, 16'h2800, 16'h1900);
        d = s + 3;

        // 5: i_done coincident with the timeout wins; stray i_done in HOLD ignored.
        s = d + 81;
        push("t5_start", s, 1'b1, 1'b0, 1'b1, S_STRT);
        m_humid = 16'h2900; m_temp = 16'h1A80;
        push("t5_done_at_timeout", s + 22, 1'b0, 1'b1, 1'b0, S_HOLD);
        pulse_done(s + 22, 1'b1, 16'h2900, 16'h1A80);
        d = s + 22;
        pulse_done(d + 5, 1'b1, 16'hFFFF, 16'hFFFF);

        // 6: enable dropped mid-MEASURE, then async reset in HOLD.
        s = d + 81;
        push("t6_start", s, 1'b1, 1'b0, 1'b1, S_STRT);
        wait_to(s + 1);
        bus.i_enable = 1'b0;
        m_humid = 16'h2A00; m_temp = 16'h1C00;
        push("t6_update_to_idle", s + 4, 1'b0, 1'b1, 1'b0, S_IDLE);
        pulse_done(s + 4, 1'b1, 16'h2A00, 16'h1C00);
        push("t6_stays_idle", s + 30, 1'b0, 1'b0, 1'b0, S_IDLE);
        wait_to(s + 30);
        bus.i_enable = 1'b1;
        wait_to(s + 40);
        rst = 1'b1;
        m_humid = 16'h0000; m_temp = 16'h0000;
        m_err = 1'b0; m_fc = 2'd0; m_retry = 2'd0;
        push("t6_async_reset", cyc, 1'b0, 1'b0, 1'b0, S_IDLE);
        step();
        step();
        rst = 1'b0;
        bus.i_enable = 1'b0;
        c = cyc;
        push("t6_after_reset", c + 4, 1'b0, 1'b0, 1'b0, S_IDLE);
        pulse_done(c + 2, 1'b1, 16'h5555, 16'h5555);
        wait_to(c + 10);

        while (sb_q.size() > 0) begin
            left = sb_q.pop_front();
            n_vec = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL %s: got no matching output by cyc=%0d; want it at cyc=%0d",
                     left.name, cyc, left.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dht11_scheduler.md
Name: dht11_scheduler

Overview:
Sequences the DHT11 sensor controller. It issues measurement start pulses periodically or on manual request, while honouring the sensor's minimum inter-read gap. It detects no-response timeouts and checksum failures, retries a bounded number of times, and holds the last good humidity/temperature for display and UART consumers. It sits between the top-level mode/button logic and the dht11 controller, and uses the same 1 us tick.

Parameters:
TICKS_PER_MS, 1000, i_tick pulses per millisecond
PERIOD_MS, 2000, interval between scheduled reads (after a success or a final failure)
MIN_GAP_MS, 1100, minimum start-to-start spacing after a failed try; also the power-up/re-enable settle time
TIMEOUT_MS, 40, maximum time from o_start to i_done before the try is declared failed
MAX_RETRY, 3, retries after the first failed try before an error is reported

Ports:
clk  in  1  system clock
rst  in  1  reset
i_tick  in  1  1 us single-cycle tick
i_enable  in  1  scheduler enable
i_trig  in  1  manual measurement request, single-cycle pulse
o_start  out  1  single-cycle start pulse to the dht11 controller
i_done  in  1  single-cycle end-of-transaction pulse from the controller
i_valid  in  1  checksum-good flag, sampled when i_done=1
i_humid  in  16  humidity from the controller, sampled when i_done&&i_valid
i_temp  in  16  temperature from the controller, sampled likewise
o_humid  out  16  last good humidity
o_temp  out  16  last good temperature
o_update  out  1  single-cycle pulse when o_humid/o_temp are loaded
o_err  out  1  set on a final failure, cleared on the next success
o_fail_code  out  2  0 none, 1 checksum, 2 timeout (cause of the most recent failed try)
o_retry  out  clog2(MAX_RETRY+1)  failed tries in the current sequence
o_busy  out  1  high in START and MEASURE
o_state  out  3  current state, for LEDs

Behaviour:
- rst is asynchronous and active-high; clk is the clock. Reset sets every output and counter to 0 and the state to IDLE.
- Timer: a prescaler counts i_tick up to TICKS_PER_MS-1 and then increments ms_cnt. Both clear on every state entry. ms_cnt saturates and does not wrap. No carry occurs without an i_tick.
- The HOLD target is a register (tgt) loaded on HOLD entry.
- IDLE: when i_enable=1, go to HOLD with tgt=MIN_GAP_MS. i_trig is ignored in IDLE.
- HOLD:
  - When i_enable=0, go to IDLE on the next edge and clear pend.
  - When ms_cnt>=tgt, go to START.
  - When i_trig arrives: if ms_cnt>=MIN_GAP_MS, go to START next cycle. Otherwise set pend, and pend forces START as soon as ms_cnt reaches MIN_GAP_MS.
  - pend clears on START entry.
- START: o_start=1 for exactly this one cycle, then go to MEASURE.
- MEASURE:
  - i_done with i_valid=1 (success): load o_humid/o_temp, pulse o_update the same cycle as the load, clear o_err/o_fail_code/o_retry, then go to HOLD with tgt=PERIOD_MS.
  - i_done with i_valid=0: fail with code 1.
  - ms_cnt reaching TIMEOUT_MS without i_done: fail with code 2.
  - If i_done and the timeout occur in the same cycle, i_done wins.
  - i_enable=0 does not abort MEASURE. The transaction completes, then the block goes to IDLE instead of HOLD; data and status still update.
- Fail handling: set o_fail_code.
  - If o_retry<MAX_RETRY: increment o_retry, go to HOLD with tgt=MIN_GAP_MS.
  - Otherwise: set o_err, clear o_retry, go to HOLD with tgt=PERIOD_MS.
- Any i_done outside MEASURE is ignored.
- i_trig in START/MEASURE is ignored and not queued.
- Latency: scheduled start occurs 1 cycle after ms_cnt reaches tgt. From i_done to o_update is 0 cycles (registered on the i_done edge).
- Reset mid-MEASURE: return to IDLE. Later i_done pulses are ignored.
- Widths: ms_cnt is clog2(max(PERIOD_MS,MIN_GAP_MS,TIMEOUT_MS)+1) bits. Parameter legality is checked at elaboration: MIN_GAP_MS<=PERIOD_MS and TIMEOUT_MS<MIN_GAP_MS.

Decomposition:
- Package dht11_sched_pkg: the state encoding (IDLE=0, HOLD=1, START=2, MEASURE=3) and the fail codes (FAIL_NONE=0, FAIL_CSUM=1, FAIL_TMO=2).
- Sub-module ms_timer: tick prescaler plus saturating ms counter, with a synchronous clear input and a ms_cnt output.

Test Plan:
All cases use TICKS_PER_MS=4, PERIOD_MS=20, MIN_GAP_MS=10, TIMEOUT_MS=5, MAX_RETRY=2, and i_tick=1 every cycle.
1. Enable after reset -> o_start at cycle 41 (10 ms settle plus 1). A model returns i_done, i_valid=1, humid=0x2D00, temp=0x1A00 -> o_update pulse, outputs hold those values, next o_start 81 cycles later.
2. i_trig at ms_cnt=3 in HOLD following a success -> pend set, o_start when ms_cnt=10. A second i_trig during MEASURE -> no extra o_start.
3. i_done with i_valid=0 three times in a row -> o_retry goes 1, 2, then 0; o_fail_code=1; o_err=1 after the third try; retries spaced by MIN_GAP_MS; next o_start after PERIOD_MS.
4. No i_done -> timeout at 5 ms, o_fail_code=2, retry. The next try succeeds -> o_err=0, o_fail_code=0, o_retry=0.
5. i_done arriving in the same cycle as the timeout, with i_valid=1 -> treated as success; no fail is recorded.
6. i_enable dropped during MEASURE -> o_start count unchanged, data loads on i_done, state goes to IDLE. Async rst pulse mid-HOLD -> all outputs 0, state IDLE.
